// File: rtl/fpu_addsub_seq.sv
// fpu_addsub_seq: multi-cycle floating-point add/subtract.
// One operation every five clocks, walking IDLE -> ALIGN -> ADD -> NORM ->
// ROUND -> IDLE. Subnormal inputs are read as signed zeros, tiny results
// flush to signed zero, and rounding is to nearest even.
//   clk, rst_n    : clock, asynchronous active-low reset
//   start, op     : issue request (sampled in IDLE only); 0 = A+B, 1 = A-B
//   Asem, Bsem    : operands {sign, exponent, fraction}
//   busy          : high whenever the FSM is not in IDLE
//   done          : one-cycle pulse when Rsem/flags carry a new result
//   Rsem, flags   : result and {invalid, overflow, underflow, inexact}
module fpu_addsub_seq #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   op,
  input  logic [EXP_W+MAN_W:0]   Asem,
  input  logic [EXP_W+MAN_W:0]   Bsem,
  output logic                   busy,
  output logic                   done,
  output logic [EXP_W+MAN_W:0]   Rsem,
  output logic [3:0]             flags
);

  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int SW  = MAN_W + 4;          // hidden + fraction + guard/round/sticky
  localparam int XW  = EXP_W + 2;          // signed working exponent
  localparam int LZW = $clog2(SW + 1);

  localparam logic [W-1:0]          QNAN       = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [EXP_W-1:0]      SHIFT_CAP  = EXP_W'(MAN_W + 3);
  localparam logic signed [XW-1:0]  EXP_ONES_S = XW'((1 << EXP_W) - 1);

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND} state_t;

  state_t                 state_q, state_d;
  logic                   busy_q, busy_d, done_q, done_d;
  logic [W-1:0]           rsem_q, rsem_d;
  logic [3:0]             flags_q, flags_d;
  logic [W-1:0]           a_q, a_d, b_q, b_d;
  logic                   spec_q, spec_d;
  logic [W-1:0]           spec_res_q, spec_res_d;
  logic [3:0]             spec_flg_q, spec_flg_d;
  logic                   sign_q, sign_d, eff_sub_q, eff_sub_d;
  logic signed [XW-1:0]   exp_q, exp_d;
  logic [SW-1:0]          sig_l_q, sig_l_d, sig_s_q, sig_s_d;
  logic [SW:0]            sum_q, sum_d;
  logic [SW-1:0]          norm_q, norm_d;
  logic                   zero_q, zero_d;

  // ---------------- ALIGN stage combinational ----------------
  logic [EXP_W-1:0]       ea, eb, el, es, dexp;
  logic [MAN_W-1:0]       ma, mb, fl, fs;
  logic                   sa, sb, sl, ss, swap;
  logic                   a_nan, b_nan, a_inf, b_inf, a_snan, b_snan;
  logic [SW-1:0]          sig_l_w, sig_s_w, sig_s_al;
  logic                   sticky_w;
  logic                   al_spec;
  logic [W-1:0]           al_spec_res;
  logic [3:0]             al_spec_flg;

  always_comb begin
    {sa, ea, ma} = a_q;
    {sb, eb, mb} = b_q;
    a_nan  = (ea == '1) && (ma != '0);
    b_nan  = (eb == '1) && (mb != '0);
    a_inf  = (ea == '1) && (ma == '0);
    b_inf  = (eb == '1) && (mb == '0);
    a_snan = a_nan && !ma[MAN_W-1];
    b_snan = b_nan && !mb[MAN_W-1];

    // Subnormals compare as zero, so their fraction is masked out here.
    swap = {eb, (eb == '0) ? '0 : mb} > {ea, (ea == '0) ? '0 : ma};
    sl = swap ? sb : sa;
    el = swap ? eb : ea;
    fl = swap ? mb : ma;
    ss = swap ? sa : sb;
    es = swap ? ea : eb;
    fs = swap ? ma : mb;

    sig_l_w = (el == '0) ? '0 : {1'b1, fl, 3'b000};
    sig_s_w = (es == '0) ? '0 : {1'b1, fs, 3'b000};
    dexp    = el - es;
    if (dexp >= SHIFT_CAP) begin
      sig_s_al = {{(SW-1){1'b0}}, |sig_s_w};
    end else begin
      sticky_w = |(sig_s_w & ~({SW{1'b1}} << dexp));
      sig_s_al = sig_s_w >> dexp;
      sig_s_al[0] = sig_s_al[0] | sticky_w;
    end
    sticky_w = 1'b0;

    al_spec     = 1'b1;
    al_spec_res = QNAN;
    al_spec_flg = 4'b0000;
    if (a_nan || b_nan) begin
      al_spec_flg = {a_snan | b_snan, 3'b000};
    end else if (a_inf && b_inf && (sa != sb)) begin
      al_spec_flg = 4'b1000;
    end else if (a_inf) begin
      al_spec_res = a_q;
    end else if (b_inf) begin
      al_spec_res = b_q;
    end else begin
      al_spec = 1'b0;
    end
  end

  // ---------------- ADD stage combinational ----------------
  logic [SW:0] sum_w;

  always_comb begin
    sum_w = eff_sub_q ? ({1'b0, sig_l_q} - {1'b0, sig_s_q})
                      : ({1'b0, sig_l_q} + {1'b0, sig_s_q});
  end

  // ---------------- NORM stage combinational ----------------
  logic [LZW-1:0] lz;

  always_comb begin
    lz = '0;
    for (int unsigned i = 0; i < SW; i++) begin
      if (sum_q[i]) lz = LZW'(SW - 1 - i);
    end
  end

  // ---------------- ROUND stage combinational ----------------
  logic                  rnd_inc, inexact_w;
  logic [MAN_W+1:0]      man_r;
  logic [MAN_W-1:0]      frac_r;
  logic signed [XW-1:0]  exp_r;

  always_comb begin
    rnd_inc   = norm_q[2] & (norm_q[1] | norm_q[0] | norm_q[3]);
    inexact_w = |norm_q[2:0];
    man_r     = {1'b0, norm_q[SW-1:3]} + (MAN_W+2)'(rnd_inc);
    // Rounding overflow of the significand (1.11..1 -> 10.0) bumps the exponent.
    exp_r     = exp_q + XW'(man_r[MAN_W+1]);
    frac_r    = man_r[MAN_W+1] ? man_r[MAN_W:1] : man_r[MAN_W-1:0];
  end

  // ---------------- next-state ----------------
  always_comb begin
    state_d    = state_q;
    done_d     = 1'b0;
    rsem_d     = rsem_q;
    flags_d    = flags_q;
    a_d        = a_q;
    b_d        = b_q;
    spec_d     = spec_q;
    spec_res_d = spec_res_q;
    spec_flg_d = spec_flg_q;
    sign_d     = sign_q;
    eff_sub_d  = eff_sub_q;
    exp_d      = exp_q;
    sig_l_d    = sig_l_q;
    sig_s_d    = sig_s_q;
    sum_d      = sum_q;
    norm_d     = norm_q;
    zero_d     = zero_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = Asem;
          b_d     = {Bsem[W-1] ^ op, Bsem[W-2:0]};
          state_d = S_ALIGN;
        end
      end
      S_ALIGN: begin
        spec_d     = al_spec;
        spec_res_d = al_spec_res;
        spec_flg_d = al_spec_flg;
        sign_d     = sl;
        eff_sub_d  = sl ^ ss;
        exp_d      = {2'b00, el};
        sig_l_d    = sig_l_w;
        sig_s_d    = sig_s_al;
        state_d    = S_ADD;
      end
      S_ADD: begin
        sum_d = sum_w;
        // Exact cancellation of unlike signs gives +0; like-signed zeros keep their sign.
        if (sum_w == '0 && eff_sub_q) sign_d = 1'b0;
        state_d = S_NORM;
      end
      S_NORM: begin
        zero_d = (sum_q == '0);
        if (sum_q[SW]) begin
          norm_d = {sum_q[SW:2], sum_q[1] | sum_q[0]};
          exp_d  = exp_q + XW'(1);
        end else begin
          norm_d = sum_q[SW-1:0] << lz;
          exp_d  = exp_q - XW'(lz);
        end
        state_d = S_ROUND;
      end
      S_ROUND: begin
        if (spec_q) begin
          rsem_d  = spec_res_q;
          flags_d = spec_flg_q;
        end else if (zero_q) begin
          rsem_d  = {sign_q, {(W-1){1'b0}}};
          flags_d = 4'b0000;
        end else if (exp_r <= 0) begin
          rsem_d  = {sign_q, {(W-1){1'b0}}};
          flags_d = 4'b0011;
        end else if (exp_r >= EXP_ONES_S) begin
          rsem_d  = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          flags_d = 4'b0101;
        end else begin
          rsem_d  = {sign_q, exp_r[EXP_W-1:0], frac_r};
          flags_d = {3'b000, inexact_w};
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rsem_q     <= '0;
      flags_q    <= '0;
      a_q        <= '0;
      b_q        <= '0;
      spec_q     <= 1'b0;
      spec_res_q <= '0;
      spec_flg_q <= '0;
      sign_q     <= 1'b0;
      eff_sub_q  <= 1'b0;
      exp_q      <= '0;
      sig_l_q    <= '0;
      sig_s_q    <= '0;
      sum_q      <= '0;
      norm_q     <= '0;
      zero_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rsem_q     <= rsem_d;
      flags_q    <= flags_d;
      a_q        <= a_d;
      b_q        <= b_d;
      spec_q     <= spec_d;
      spec_res_q <= spec_res_d;
      spec_flg_q <= spec_flg_d;
      sign_q     <= sign_d;
      eff_sub_q  <= eff_sub_d;
      exp_q      <= exp_d;
      sig_l_q    <= sig_l_d;
      sig_s_q    <= sig_s_d;
      sum_q      <= sum_d;
      norm_q     <= norm_d;
      zero_q     <= zero_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign Rsem  = rsem_q;
  assign flags = flags_q;

endmodule

// File: doc/fpu_addsub_seq.md
FPU_ADDSUB_SEQ -- requirements
Module: fpu_addsub_seq

Parameters
REQ-001 The block SHALL have parameter EXP_W, default 5, meaning exponent field width.
REQ-002 The block SHALL have parameter MAN_W, default 10, meaning stored mantissa (fraction) width.
REQ-003 Word width W SHALL be 1+EXP_W+MAN_W, laid out {sign, exponent, fraction}, with bias 2^(EXP_W-1)-1.

Interface
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  request; sampled only in IDLE.
REQ-007 op  input  1  0 = Asem+Bsem, 1 = Asem-Bsem.
REQ-008 Asem  input  W  operand A.
REQ-009 Bsem  input  W  operand B.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle pulse when Rsem and flags are valid.
REQ-012 Rsem  output  W  registered result, held until next done.
REQ-013 flags  output  4  {invalid, overflow, underflow, inexact}, registered with Rsem.

Function
REQ-014 FSM states: IDLE, ALIGN, ADD, NORM, ROUND; IDLE->ALIGN on start, then one state per clock, ROUND->IDLE unconditionally.
REQ-015 On start in IDLE: capture Asem, Bsem, op; B sign inverted when op=1.
REQ-016 Latency fixed: done high in the 5th cycle after the start-sampling edge, coincident with return to IDLE.
REQ-017 start while busy SHALL be ignored; operands changing while busy SHALL not affect the result.
REQ-018 start high in the done cycle SHALL be accepted (back-to-back issue, throughput one op per 5 cycles).
REQ-019 ALIGN: swap so the larger-magnitude operand is first; shift smaller significand (hidden 1 restored) right by exponent difference, keeping guard, round and sticky bits; shifts >= MAN_W+3 collapse to sticky only.
REQ-020 ADD: add or subtract significands per effective sign; result sign = sign of larger magnitude.
REQ-021 NORM: single-cycle leading-zero count and left shift, or right shift by 1 on carry-out; exponent adjusted accordingly.
REQ-022 ROUND: round-to-nearest-even using guard/round/sticky; mantissa carry from rounding increments exponent.
REQ-023 Exact zero result of unlike-sign operands SHALL be +0; (+0)+(+0)=+0, (-0)+(-0)=-0.
REQ-024 Subnormal inputs SHALL be treated as zero of same sign; results below the minimum normal SHALL flush to signed zero with underflow=1.
REQ-025 Result exponent reaching all-ones SHALL yield signed infinity with overflow=1, inexact=1.
REQ-026 inexact=1 whenever any discarded bit was nonzero.
REQ-027 Any NaN input, or inf minus inf (effective), SHALL give canonical quiet NaN {0, all-ones exp, 1 followed by zeros}; invalid=1 only for inf-inf or signalling NaN input.
REQ-028 inf plus finite SHALL return that infinity, flags all zero.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, busy=0, done=0, Rsem=0, flags=0, independent of clk.
REQ-030 Reset mid-operation SHALL abort the operation with no done pulse; first start after rst_n rises SHALL behave normally.

Verification (defaults EXP_W=5, MAN_W=10)
REQ-031 A=0x4000, B=0x4000, op=0 -> done 5 cycles after start, Rsem=0x4400, flags=0.
REQ-032 A=0x4000, B=0x4000, op=1 -> Rsem=0x0000 (+0), flags=0; same with op=0, B=0xC000 -> 0x0000.
REQ-033 A=0x3C00, B=0x1000 -> 0x3C00 inexact=1 (tie to even down); A=0x3C01, B=0x1000 -> 0x3C02 inexact=1 (tie to even up).
REQ-034 A=0x7BFF, B=0x7BFF -> Rsem=0x7C00, overflow=1, inexact=1; A=0x7C00, B=0x7C00, op=1 -> 0x7E00, invalid=1.
REQ-035 start asserted again in done cycle, then start pulsed while busy -> exactly two done pulses, second result from second operands only.
REQ-036 rst_n pulsed low during NORM -> outputs zero asynchronously, no done pulse, next op (0x4000+0x4000) returns 0x4400.
